// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter that shares the register-file write port between two requesters.
// Define REG_FILE_WR_ARBITER_CLEAR_EN to zero x1..x31 after every reset before any grant.
module reg_file_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clearReg;

`ifdef REG_FILE_WR_ARBITER_CLEAR_EN
  typedef enum logic {StClear, StRun} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastReg = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrCnt_q, clrCnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StClear;
      clrCnt_q <= ADDR_WIDTH'(1);
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  // The counter stops at the last register rather than wrapping back to x0.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    clearing = 1'b0;
    case (state_q)
      StClear: begin
        clearing = 1'b1;
        if (clrCnt_q == LastReg) begin
          state_d = StRun;
        end else begin
          clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign clearReg = clrCnt_q;
  assign busy     = (state_q == StClear);
`else
  assign clearing = 1'b0;
  assign clearReg = '0;
  assign busy     = 1'b0;
`endif

  // lastGrant_q = 1 means requester 1 won most recently, so requester 0 wins the first contest.
  logic                  lastGrant_q, lastGrant_d;
  logic                  wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] wrReg_q, wrReg_d;
  logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
  logic                  runOk;
  logic                  grant0, grant1;

  assign runOk  = rst_n & ~busy;
  assign grant0 = runOk & req0_valid & (~req1_valid | lastGrant_q);
  assign grant1 = runOk & req1_valid & (~req0_valid | ~lastGrant_q);

  always_comb begin
    lastGrant_d = lastGrant_q;
    wrEn_d      = 1'b0;
    wrReg_d     = wrReg_q;
    wrData_d    = wrData_q;
    if (clearing) begin
      wrEn_d   = 1'b1;
      wrReg_d  = clearReg;
      wrData_d = '0;
    end else if (grant0) begin
      lastGrant_d = 1'b0;
      wrEn_d      = |req0_reg;
      wrReg_d     = req0_reg;
      wrData_d    = req0_data;
    end else if (grant1) begin
      lastGrant_d = 1'b1;
      wrEn_d      = |req1_reg;
      wrReg_d     = req1_reg;
      wrData_d    = req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= 1'b1;
      wrEn_q      <= 1'b0;
      wrReg_q     <= '0;
      wrData_q    <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wrEn_q      <= wrEn_d;
      wrReg_q     <= wrReg_d;
      wrData_q    <= wrData_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = wrEn_q;
  assign wr_reg     = wrReg_q;
  assign wr_data    = wrData_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Randomized bench for reg_file_wr_arbiter against a transaction-level model of the arbiter.
// Follows REG_FILE_WR_ARBITER_CLEAR_EN to decide whether a clear sequence is expected.
module tb_reg_file_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_FILE_WR_ARBITER_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, wr_reg;
  logic [DW-1:0] req0_data, req1_data, wr_data;
  logic          wr_en, busy;

  int checks = 0;
  int errors = 0;

  // Model: who won last, how far the clear has got, and the write the port must show next.
  int            mLast;
  bit            mInReset;
  int            mClearNext;
  bit            mWrEn;
  int            mWrReg;
  logic [DW-1:0] mWrData;
  bit            mT0, mT1;

  reg_file_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit expBusy();
    if (mInReset) return ClrEn;
    return (mClearNext <= 31);
  endfunction

  function automatic bit expReady(input int n);
    if (mInReset || expBusy()) return 1'b0;
    if (n == 0) return req0_valid && (!req1_valid || mLast == 1);
    return req1_valid && (!req0_valid || mLast == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mInReset   = 1'b1;
    mLast      = 1;
    mClearNext = ClrEn ? 1 : 32;
    mWrEn      = 1'b0;
    mWrReg     = 0;
    mWrData    = '0;
  endtask

  task automatic modelEdge();
    mT0 = 1'b0;
    mT1 = 1'b0;
    if (mInReset) return;
    if (mClearNext <= 31) begin
      mWrEn   = 1'b1;
      mWrReg  = mClearNext;
      mWrData = '0;
      mClearNext++;
    end else begin
      mT0 = expReady(0);
      mT1 = expReady(1);
      if (mT0) begin
        mWrEn = (req0_reg != 0); mWrReg = int'(req0_reg); mWrData = req0_data; mLast = 0;
      end else if (mT1) begin
        mWrEn = (req1_reg != 0); mWrReg = int'(req1_reg); mWrData = req1_data; mLast = 1;
      end else begin
        mWrEn = 1'b0;
      end
    end
  endtask

  // Advance one clock; a granted requester withdraws its valid afterwards.
  task automatic stepEdge();
    @(posedge clk);
    modelEdge();
    #2;
    if (mT0) req0_valid = 1'b0;
    if (mT1) req1_valid = 1'b0;
  endtask

  task automatic enterReset();
    rst_n = 1'b0;
    modelReset();
  endtask

  task automatic leaveReset();
    rst_n    = 1'b1;
    mInReset = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("ready0", req0_ready, expReady(0));
    checkOutput("ready1", req1_ready, expReady(1));
    checkOutput("bothReady", req0_ready & req1_ready, 0);
    checkOutput("busy", busy, expBusy());
    checkOutput("wrEn", wr_en, mWrEn);
    if (mWrEn) begin
      checkOutput("wrReg", wr_reg, mWrReg);
      checkOutput("wrData", wr_data, mWrData);
    end
  end

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      stepEdge();
      if (i == cycles / 2) begin
        enterReset();
        repeat (3) stepEdge();
        leaveReset();
      end
      if (!req0_valid && $urandom_range(0, 9) < 7) begin
        req0_valid = 1'b1;
        req0_reg   = AW'($urandom_range(0, 31));
        req0_data  = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 9) < 7) begin
        req1_valid = 1'b1;
        req1_reg   = AW'($urandom_range(0, 31));
        req1_data  = $urandom;
      end
    end
  endtask

  initial begin
    int guard;
    enterReset();
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h77;
    req1_valid = 1'b1; req1_reg = 5'd8; req1_data = 32'h88;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstWrEn", wr_en, 0);
      checkOutput("rstWrReg", wr_reg, 0);
      checkOutput("rstWrData", wr_data, 0);
      checkOutput("rstReady0", req0_ready, 0);
      checkOutput("rstBusy", busy, ClrEn);
    end
    @(posedge clk);
    #2;
    leaveReset();

`ifdef REG_FILE_WR_ARBITER_CLEAR_EN
    repeat (12) stepEdge();
    checkOutput("clrAt12", wr_reg, 12);
    checkOutput("clrAt12En", wr_en, 1);
    enterReset();
    repeat (2) stepEdge();
    @(negedge clk);
    checkOutput("midRstWrEn", wr_en, 0);
    checkOutput("midRstBusy", busy, 1);
    stepEdge();
    leaveReset();
    stepEdge();
    checkOutput("clrRestart", wr_reg, 1);
    checkOutput("clrRestartData", wr_data, 0);
    guard = 0;
    while (expBusy() && guard < 40) begin
      stepEdge();
      guard++;
    end
    checkOutput("clrLastReg", wr_reg, 31);
    checkOutput("clrDoneBusy", busy, 0);
`else
    guard = 0;
    checkOutput("noClrBusy", busy, 0);
`endif
    #1;
    checkOutput("firstContest0", req0_ready, 1);
    checkOutput("firstContest1", req1_ready, 0);
    stepEdge();
    checkOutput("grant7En", wr_en, 1);
    checkOutput("grant7Reg", wr_reg, 7);
    checkOutput("grant7Data", wr_data, 32'h77);
    #1;
    checkOutput("loneReady1", req1_ready, 1);
    stepEdge();
    checkOutput("grant8Reg", wr_reg, 8);
    checkOutput("grant8Data", wr_data, 32'h88);

    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checkOutput("beefReady", req0_ready, 1);
    stepEdge();
    checkOutput("beefEn", wr_en, 1);
    checkOutput("beefReg", wr_reg, 5);
    checkOutput("beefData", wr_data, 32'hDEADBEEF);

    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'h1234;
    #1;
    checkOutput("x0Ready", req1_ready, 1);
    stepEdge();
    checkOutput("x0NoWrite", wr_en, 0);

    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("altReady0", req0_ready, (i % 2 == 0));
      checkOutput("altReady1", req1_ready, (i % 2 == 1));
      stepEdge();
      checkOutput("altReg", wr_reg, (i % 2 == 0) ? 1 : 2);
      checkOutput("altData", wr_data, (i % 2 == 0) ? 32'h11 + 32'h100 * (i / 2) : 32'h22 + 32'h100 * (i / 2));
      if (!req0_valid) begin
        req0_valid = 1'b1; req0_data = 32'h11 + 32'h100 * (i / 2 + 1);
      end
      if (!req1_valid) begin
        req1_valid = 1'b1; req1_data = 32'h22 + 32'h100 * (i / 2 + 1);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    applyStimulus(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
